// File: rtl/round_judge.sv
// round_judge -- referee for a two-player reaction / tug-of-war game.
//
// Compile-time option:
//   ROUND_JUDGE_FALSE_START_PENALTY_EN
//     defined   : a false start (press while leds_on=0 or fake=1) awards the opponent.
//     undefined : a false start still ends the round (winrnd) but leaves the rope,
//                 last_winner and the scores alone.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   slowen256    one-cycle timing enable pulse (speed window / hold timing)
//   pbl, pbr     raw asynchronous left/right buttons
//   clear, leds_on, fake, speed_round, update
//                round-phase indicators from the game controller
//   winrnd       round decided (level, cleared by clear)
//   wingame      rope reached an end (level, cleared by update rising edge)
//   over         match decided (level, cleared only by reset)
//   winspeed     speed window closed (level while the speed FSM is in SPD_DONE)
//   speed_exit   one-cycle pulse when the speed display time has elapsed
//   rope_pos     rope position 0..ROPE_END, centre ROPE_END/2
//   score_l/_r   games won per player (saturate at 3)
//   last_winner  0 = left, 1 = right
//
// The speed FSM state is kept in the named signal spd_state so checkers can bind to it.
module round_judge #(
  parameter int GAMES_TO_WIN = 2,
  parameter int SPEED_WINDOW = 4,
  parameter int ROPE_END     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen256,
  input  logic       pbl,
  input  logic       pbr,
  input  logic       clear,
  input  logic       leds_on,
  input  logic       fake,
  input  logic       speed_round,
  input  logic       update,
  output logic       winrnd,
  output logic       wingame,
  output logic       over,
  output logic       winspeed,
  output logic       speed_exit,
  output logic [3:0] rope_pos,
  output logic [1:0] score_l,
  output logic [1:0] score_r,
  output logic       last_winner
);

  localparam logic [3:0] CENTRE  = 4'(ROPE_END / 2);
  localparam logic [3:0] END_POS = 4'(ROPE_END);
  localparam logic [1:0] WIN_GAMES = 2'(GAMES_TO_WIN);
  localparam int         WCW = (SPEED_WINDOW > 1) ? $clog2(SPEED_WINDOW) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(SPEED_WINDOW - 1);

  typedef enum logic [1:0] {SPD_IDLE, SPD_COUNT, SPD_DONE, SPD_HOLD} spd_state_t;

  spd_state_t     spd_state;
  logic [2:0]     sync_l, sync_r;
  logic           press_l, press_r;
  logic           sr_d, upd_d;
  logic [3:0]     cnt_l, cnt_r;
  logic [WCW-1:0] win_cnt;
  logic           hold_cnt;

  // Combinational decision signals.
  logic       armed, hit, good_start;
  logic       rnd_award, rnd_to_r;
  logic       spd_award, spd_to_r, window_end;
  logic       award, award_to_r;
  logic       sr_rise, upd_rise;
  logic [3:0] cnt_l_nxt, cnt_r_nxt, rope_nxt;
  logic [1:0] inc_l, inc_r;

  assign sr_rise    = speed_round & ~sr_d;
  assign upd_rise   = update & ~upd_d;
  assign armed      = ~clear & ~speed_round & ~winrnd & ~over;
  // Simultaneous left and right presses cancel each other; detection stays armed.
  assign hit        = armed & (press_l ^ press_r);
  assign good_start = leds_on & ~fake;

`ifdef ROUND_JUDGE_FALSE_START_PENALTY_EN
  assign rnd_award = hit;
  assign rnd_to_r  = good_start ? press_r : press_l;
`else
  assign rnd_award = hit & good_start;
  assign rnd_to_r  = press_r;
`endif

  assign cnt_l_nxt  = (press_l && cnt_l != 4'hF) ? cnt_l + 4'd1 : cnt_l;
  assign cnt_r_nxt  = (press_r && cnt_r != 4'hF) ? cnt_r + 4'd1 : cnt_r;
  // Presses in the final window cycle still count toward the comparison.
  assign window_end = (spd_state == SPD_COUNT) && slowen256 && (win_cnt == WIN_LAST);
  assign spd_award  = window_end && (cnt_l_nxt != cnt_r_nxt) && !over;
  assign spd_to_r   = cnt_r_nxt > cnt_l_nxt;

  // The speed result takes precedence if both sources fire in one cycle.
  assign award      = spd_award | rnd_award;
  assign award_to_r = spd_award ? spd_to_r : rnd_to_r;

  always_comb begin
    rope_nxt = rope_pos;
    if (award_to_r) begin
      if (rope_pos != END_POS) rope_nxt = rope_pos + 4'd1;
    end else begin
      if (rope_pos != 4'd0) rope_nxt = rope_pos - 4'd1;
    end
  end

  assign inc_l = (score_l == 2'd3) ? 2'd3 : score_l + 2'd1;
  assign inc_r = (score_r == 2'd3) ? 2'd3 : score_r + 2'd1;

  // Speed-round FSM with registered winspeed / speed_exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spd_state  <= SPD_IDLE;
      cnt_l      <= 4'd0;
      cnt_r      <= 4'd0;
      win_cnt    <= '0;
      hold_cnt   <= 1'b0;
      winspeed   <= 1'b0;
      speed_exit <= 1'b0;
    end else begin
      speed_exit <= 1'b0;
      case (spd_state)
        SPD_IDLE: begin
          if (sr_rise) begin
            spd_state <= SPD_COUNT;
            cnt_l     <= 4'd0;
            cnt_r     <= 4'd0;
            win_cnt   <= '0;
          end
        end
        SPD_COUNT: begin
          cnt_l <= cnt_l_nxt;
          cnt_r <= cnt_r_nxt;
          if (slowen256) begin
            if (window_end) begin
              spd_state <= SPD_DONE;
              winspeed  <= 1'b1;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end
        SPD_DONE: begin
          if (!speed_round) begin
            spd_state <= SPD_HOLD;
            winspeed  <= 1'b0;
            hold_cnt  <= 1'b0;
          end
        end
        SPD_HOLD: begin
          if (slowen256) begin
            if (hold_cnt) begin
              speed_exit <= 1'b1;
              spd_state  <= SPD_IDLE;
            end else begin
              hold_cnt <= 1'b1;
            end
          end
        end
        default: spd_state <= SPD_IDLE;
      endcase
    end
  end

  // Input conditioning, round decision, rope and scores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_l      <= 3'b000;
      sync_r      <= 3'b000;
      press_l     <= 1'b0;
      press_r     <= 1'b0;
      sr_d        <= 1'b0;
      upd_d       <= 1'b0;
      winrnd      <= 1'b0;
      wingame     <= 1'b0;
      over        <= 1'b0;
      rope_pos    <= CENTRE;
      score_l     <= 2'd0;
      score_r     <= 2'd0;
      last_winner <= 1'b0;
    end else begin
      // [0],[1] synchronise; [2] is the previous synchronised level for edge detect.
      sync_l  <= {sync_l[1:0], pbl};
      sync_r  <= {sync_r[1:0], pbr};
      press_l <= sync_l[1] & ~sync_l[2];
      press_r <= sync_r[1] & ~sync_r[2];
      sr_d    <= speed_round;
      upd_d   <= update;

      if (hit)        winrnd <= 1'b1;
      else if (clear) winrnd <= 1'b0;

      if (award) last_winner <= award_to_r;

      if (upd_rise) begin
        rope_pos <= CENTRE;
        wingame  <= 1'b0;
        if (wingame && !over) begin
          if (rope_pos == END_POS) begin
            score_r <= inc_r;
            if (inc_r == WIN_GAMES) over <= 1'b1;
          end else if (rope_pos == 4'd0) begin
            score_l <= inc_l;
            if (inc_l == WIN_GAMES) over <= 1'b1;
          end
        end
      end else if (award) begin
        rope_pos <= rope_nxt;
        if (rope_nxt == 4'd0 || rope_nxt == END_POS) wingame <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge -- directed scenarios with literal expectations, then randomized
// stimulus, all checked every cycle against a behavioural model of the referee.
module tb_round_judge;

  localparam int G  = 2;
  localparam int SW = 4;
  localparam int RE = 8;

  logic       clk = 1'b0;
  logic       rst, slowen256, pbl, pbr, clear, leds_on, fake, speed_round, update;
  logic       winrnd, wingame, over, winspeed, speed_exit, last_winner;
  logic [3:0] rope_pos;
  logic [1:0] score_l, score_r;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  round_judge #(.GAMES_TO_WIN(G), .SPEED_WINDOW(SW), .ROPE_END(RE)) dut (
    .clk(clk), .rst(rst), .slowen256(slowen256), .pbl(pbl), .pbr(pbr),
    .clear(clear), .leds_on(leds_on), .fake(fake), .speed_round(speed_round),
    .update(update), .winrnd(winrnd), .wingame(wingame), .over(over),
    .winspeed(winspeed), .speed_exit(speed_exit), .rope_pos(rope_pos),
    .score_l(score_l), .score_r(score_r), .last_winner(last_winner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Button histories: index 0 is the level sampled at this edge, index k the level k edges ago.
  bit hl[5], hr[5];
  int m_rope, m_sl, m_sr, m_phase, m_cl, m_cr, m_win, m_hold;
  bit m_winrnd, m_wingame, m_over, m_lw, m_exit, m_prev_sr, m_prev_up;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin hl[i] = 0; hr[i] = 0; end
    m_rope = RE / 2; m_sl = 0; m_sr = 0;
    m_phase = 0; m_cl = 0; m_cr = 0; m_win = 0; m_hold = 0;
    m_winrnd = 0; m_wingame = 0; m_over = 0; m_lw = 0; m_exit = 0;
    m_prev_sr = 0; m_prev_up = 0;
  endtask

  task automatic model_step();
    bit pl, pr, armed, aw, aw_r, up_edge, sr_edge;
    for (int i = 4; i > 0; i--) begin hl[i] = hl[i-1]; hr[i] = hr[i-1]; end
    hl[0] = pbl; hr[0] = pbr;
    // A press is seen three edges after the pin is first sampled high.
    pl = hl[3] && !hl[4];
    pr = hr[3] && !hr[4];
    sr_edge = speed_round && !m_prev_sr;
    up_edge = update && !m_prev_up;
    aw = 0; aw_r = 0;

    armed = !clear && !speed_round && !m_winrnd && !m_over;
    if (armed && (pl != pr)) begin
      m_winrnd = 1;
      if (leds_on && !fake) begin
        aw = 1; aw_r = pr;
      end else begin
`ifdef ROUND_JUDGE_FALSE_START_PENALTY_EN
        aw = 1; aw_r = pl;
`endif
      end
    end else if (clear) begin
      m_winrnd = 0;
    end

    m_exit = 0;
    case (m_phase)
      0: if (sr_edge) begin m_phase = 1; m_cl = 0; m_cr = 0; m_win = 0; end
      1: begin
        if (pl && m_cl < 15) m_cl++;
        if (pr && m_cr < 15) m_cr++;
        if (slowen256) begin
          m_win++;
          if (m_win == SW) begin
            m_phase = 2;
            if (m_cl != m_cr && !m_over) begin aw = 1; aw_r = (m_cr > m_cl); end
          end
        end
      end
      2: if (!speed_round) begin m_phase = 3; m_hold = 0; end
      default: if (slowen256) begin
        m_hold++;
        if (m_hold == 2) begin m_exit = 1; m_phase = 0; end
      end
    endcase

    if (up_edge) begin
      if (m_wingame && !m_over) begin
        if (m_rope == RE) begin
          if (m_sr < 3) m_sr++;
          if (m_sr == G) m_over = 1;
        end else if (m_rope == 0) begin
          if (m_sl < 3) m_sl++;
          if (m_sl == G) m_over = 1;
        end
      end
      m_rope = RE / 2;
      m_wingame = 0;
    end else if (aw) begin
      if (aw_r) m_rope = (m_rope < RE) ? m_rope + 1 : RE;
      else      m_rope = (m_rope > 0) ? m_rope - 1 : 0;
      if (m_rope == 0 || m_rope == RE) m_wingame = 1;
    end
    if (aw) m_lw = aw_r;
    m_prev_sr = speed_round;
    m_prev_up = update;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("winrnd",      int'(winrnd),      int'(m_winrnd));
      chk("wingame",     int'(wingame),     int'(m_wingame));
      chk("over",        int'(over),        int'(m_over));
      chk("winspeed",    int'(winspeed),    (m_phase == 2) ? 1 : 0);
      chk("speed_exit",  int'(speed_exit),  int'(m_exit));
      chk("rope_pos",    int'(rope_pos),    m_rope);
      chk("score_l",     int'(score_l),     m_sl);
      chk("score_r",     int'(score_r),     m_sr);
      chk("last_winner", int'(last_winner), int'(m_lw));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slowen256 = 0; pbl = 0; pbr = 0; clear = 0; leds_on = 0;
    fake = 0; speed_round = 0; update = 0;
  endtask

  // Asserts reset one time unit after an edge (mid-cycle), holds two edges.
  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #1;
    chk_on = 1;
    tick(); tick();
    rst = 1;
  endtask

  task automatic pulse_btn(input bit l, input bit r);
    pbl = l; pbr = r;
    tick();
    pbl = 0; pbr = 0;
    tick();
  endtask

  task automatic slow_pulse();
    slowen256 = 1; tick();
    slowen256 = 0; tick();
  endtask

  task automatic right_award_round();
    pulse_btn(0, 1);
    tick(); tick();
    clear = 1; tick();
    clear = 0; tick();
  endtask

  task automatic rcyc(input bit btn);
    pbl = btn && ($urandom_range(0, 2) == 0);
    pbr = btn && ($urandom_range(0, 2) == 0);
    slowen256 = ($urandom_range(0, 3) == 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    idle_inputs();
    tick(); tick();

    // Reset state pinned by literals.
    do_reset();
    chk("rst_rope", int'(rope_pos), 4);
    chk("rst_score_r", int'(score_r), 0);
    chk("rst_winrnd", int'(winrnd), 0);

    // Valid right press: winrnd four edges after the pin rises, rope 4 -> 5.
    leds_on = 1;
    pulse_btn(0, 1);
    tick();
    chk("r027_winrnd_early", int'(winrnd), 0);
    tick();
    chk("r027_winrnd", int'(winrnd), 1);
    chk("r027_rope", int'(rope_pos), 5);
    chk("r027_lw", int'(last_winner), 1);
    tick();
    clear = 1; tick();
    chk("r027_winrnd_fall", int'(winrnd), 0);
    clear = 0; tick();

    // False start by the left player.
    do_reset();
    leds_on = 0;
    pulse_btn(1, 0);
    tick(); tick();
    chk("r028_winrnd", int'(winrnd), 1);
`ifdef ROUND_JUDGE_FALSE_START_PENALTY_EN
    chk("r028_rope", int'(rope_pos), 5);
`else
    chk("r028_rope", int'(rope_pos), 4);
`endif
    clear = 1; tick(); clear = 0; tick();

    // Simultaneous presses cancel, a later single left press wins.
    do_reset();
    leds_on = 1;
    pulse_btn(1, 1);
    repeat (4) tick();
    chk("r031_no_winrnd", int'(winrnd), 0);
    pulse_btn(1, 0);
    tick(); tick();
    chk("r031_winrnd", int'(winrnd), 1);
    chk("r031_lw", int'(last_winner), 0);
    chk("r031_rope", int'(rope_pos), 3);
    clear = 1; tick(); clear = 0; tick();

    // Speed round: left 3, right 5 presses.
    do_reset();
    speed_round = 1; tick();
    for (int i = 0; i < 5; i++) pulse_btn(i < 3, 1);
    repeat (3) tick();
    repeat (SW) slow_pulse();
    chk("r029_winspeed", int'(winspeed), 1);
    chk("r029_rope", int'(rope_pos), 5);
    chk("r029_lw", int'(last_winner), 1);
    speed_round = 0; tick();
    chk("r029_winspeed_fall", int'(winspeed), 0);
    slow_pulse();
    chk("r029_exit_early", int'(speed_exit), 0);
    slowen256 = 1; tick();
    chk("r029_exit", int'(speed_exit), 1);
    slowen256 = 0; tick();
    chk("r029_exit_fall", int'(speed_exit), 0);

    // Two games to the right player finish the match.
    do_reset();
    leds_on = 1;
    repeat (4) right_award_round();
    chk("r030_rope_end", int'(rope_pos), 8);
    chk("r030_wingame", int'(wingame), 1);
    update = 1; tick(); update = 0; tick();
    chk("r030_score1", int'(score_r), 1);
    chk("r030_rope_ctr", int'(rope_pos), 4);
    chk("r030_wingame_clr", int'(wingame), 0);
    repeat (4) right_award_round();
    update = 1; tick(); update = 0; tick();
    chk("r030_score2", int'(score_r), 2);
    chk("r030_over", int'(over), 1);
    pulse_btn(0, 1);
    repeat (3) tick();
    chk("r030_ignored_winrnd", int'(winrnd), 0);
    chk("r030_ignored_rope", int'(rope_pos), 4);

    // Reset in the middle of a speed window with counts 2/3.
    do_reset();
    leds_on = 1;
    right_award_round();
    speed_round = 1; tick();
    pulse_btn(1, 1); pulse_btn(1, 1); pulse_btn(0, 1);
    repeat (3) tick();
    slow_pulse();
    speed_round = 0;
    rst = 0;
    #1;
    chk("r032_rope", int'(rope_pos), 4);
    chk("r032_lw", int'(last_winner), 0);
    chk("r032_winspeed", int'(winspeed), 0);
    chk("r032_winrnd", int'(winrnd), 0);
    tick(); rst = 1;
    repeat (8) slow_pulse();
    chk("r032_no_winspeed", int'(winspeed), 0);

    // Randomized phase.
    do_reset();
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          clear = 0;
          leds_on = ($urandom_range(0, 3) != 0);
          fake = ($urandom_range(0, 4) == 0);
          repeat ($urandom_range(6, 20)) rcyc(1);
          pbl = 0; pbr = 0;
          clear = 1; rcyc(0); rcyc(0);
          clear = 0;
        end
        4, 5: begin
          speed_round = 1;
          repeat ($urandom_range(20, 50)) rcyc(1);
          pbl = 0; pbr = 0;
          speed_round = 0;
          repeat (40) rcyc(0);
        end
        6, 7, 8: begin
          update = 1; rcyc(0);
          update = 0; rcyc(0);
        end
        default: do_reset();
      endcase
    end
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
